reg_bus_arbiter: RTL and testbench
==================================

// Module: reg_bus_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing the single 16-bit register bus (bus_cmd_valid/bus_op/
//  bus_addr/bus_wr_data -> bus_rd_data) between NUM_REQ requesters (sequencer agents, config
//  engine, debug port). Serialises one transaction at a time and returns read data or write ack
//  to the winning requester. Sits between requesters and the DUT register slave.
// PARAMETERS
//  NUM_REQ    4   number of requesters, 2..8
//  AW         16  bus address width
//  DW         16  bus data width
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  req_valid    in   NUM_REQ     per-requester transaction request
//  req_ready    out  NUM_REQ     one-hot accept; transfer when req_valid[i] & req_ready[i]
//  req_op       in   NUM_REQ     1=write, 0=read
//  req_addr     in   NUM_REQ*AW  packed address, requester i at [i*AW +: AW]
//  req_wdata    in   NUM_REQ*DW  packed write data, requester i at [i*DW +: DW]
//  rsp_valid    out  NUM_REQ     one-cycle response pulse to the accepted requester
//  rsp_rdata    out  DW          read data, valid with rsp_valid; 0 for writes
//  bus_cmd_valid out 1           register-bus command strobe
//  bus_op       out  1           1=write, 0=read
//  bus_addr     out  AW          register-bus address
//  bus_wr_data  out  DW          register-bus write data
//  bus_rd_data  in   DW          slave read data, registered by slave: valid cycle after command
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): all outputs 0, FSM=IDLE, rr pointer=NUM_REQ-1
//    (requester 0 has highest priority first). Reset mid-transaction aborts it: no rsp_valid,
//    bus_cmd_valid drops immediately.
//  - FSM: IDLE -> CMD -> (read: RDWAIT ->) RSP -> IDLE.
//  - IDLE: req_ready = one-hot grant from round-robin over req_valid, search starting at
//    ptr+1 mod NUM_REQ; zero if no req_valid. On accept (cycle T) latch index, op, addr, wdata;
//    ptr <= granted index; go CMD. req_ready is 0 in all other states.
//  - CMD (T+1): bus_cmd_valid=1 for exactly one cycle, bus_op/addr/wr_data from latch (all bus
//    outputs registered). Write -> RSP; read -> RDWAIT.
//  - RDWAIT (T+2): capture bus_rd_data at end of cycle into rsp data register.
//  - RSP: rsp_valid[idx]=1 one cycle; rsp_rdata = captured data (read) or 0 (write).
//    Write rsp at T+2, read rsp at T+3. Next accept earliest in following IDLE cycle
//    (write every 3 cycles, read every 4).
//  - bus_op/bus_addr/bus_wr_data hold last values when bus_cmd_valid=0; rsp_rdata holds until
//    next RSP.
//  - Requesters must hold req_* stable until accepted; withdrawal before accept is legal and
//    simply loses arbitration. req_valid during busy states is ignored (no queueing).
//  - Simultaneous requests: exactly one granted; fairness: a continuously requesting agent is
//    granted within NUM_REQ transactions.
//  - Single requester: granted every transaction regardless of ptr.
//  - Requester may re-request in the cycle of its rsp_valid; it is considered in next IDLE.
// STRUCTURE
//  - Package reg_bus_arb_pkg: state enum {IDLE,CMD,RDWAIT,RSP}, BUS_OP_RD=1'b0,
//    BUS_OP_WR=1'b1, default AW/DW localparams.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr idx, enable; outputs one-hot gnt and
//    encoded index; purely combinational, reused elsewhere.
//  - Top holds FSM, latches, rr pointer, bus output and response registers.
// TESTING
//  1. Reset, rd_n=0 mid-CMD of write to 0x9 -> bus_cmd_valid=0 at once, no rsp_valid, all outs 0.
//  2. Req0 write addr 0x9 data 0x0001 -> bus_cmd_valid one cycle at T+1, bus_op=1, rsp_valid[0]
//     at T+2, rsp_rdata=0; slave invert reads back 1.
//  3. Req1 write 0x5=0x1234, then read 0x5 -> read rsp_valid[1] at T+3, rsp_rdata=0x1234.
//  4. All 4 req_valid held high, reads to 0x6 -> grant order 0,1,2,3,0; one bus cmd per 4 cycles.
//  5. Req2 only, back-to-back writes 0x6=0xBEEF/0xCAFE -> accepts 3 cycles apart, read 0x6=0xCAFE.
//  6. Read unmapped addr 0x7 -> rsp_rdata=0x0000; req3 valid during busy read not accepted
//     until IDLE.

Source files
------------

// File: rtl/reg_bus_arb_pkg.sv
// Shared types and constants for the register-bus arbiter.
package reg_bus_arb_pkg;

    // Transaction sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2,
        RSP    = 2'd3
    } arb_state_e;

    // Register-bus opcode encoding.
    localparam logic BUS_OP_RD = 1'b0;
    localparam logic BUS_OP_WR = 1'b1;

    // Default geometry.
    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_AW      = 16;
    localparam int unsigned DEF_DW      = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past ptr and wraps.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    // Walk requesters in priority order ptr+1, ptr+2, ... and take the first one asserted.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (enable && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin sequencer sharing one register bus between NUM_REQ requesters.
// One transaction in flight at a time: IDLE -> CMD -> (RDWAIT ->) RSP -> IDLE.
module reg_bus_arbiter import reg_bus_arb_pkg::*; #(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_op,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  bus_cmd_valid,
    output logic                  bus_op,
    output logic [AW-1:0]         bus_addr,
    output logic [DW-1:0]         bus_wr_data,
    input  logic [DW-1:0]         bus_rd_data
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    arb_state_e           state_q;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        idx_q;
    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 arb_enable;
    logic                 accept;
    logic                 sel_op;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;
    logic [NUM_REQ-1:0]   idx_onehot;

    // Grants are only offered while idle; reset forces them low too.
    assign arb_enable = (state_q == IDLE) && rst_n;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (arb_enable),
        .gnt    (gnt),
        .idx    (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);

    // One-hot mux of the winning requester's command fields.
    always_comb begin
        sel_op    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_op    = req_op[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Decode the latched requester index for the response pulse.
    always_comb begin
        idx_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx_onehot[i] = (idx_q == IW'(i));
        end
    end

    // Sequencer FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= IW'(NUM_REQ - 1);
            idx_q         <= '0;
            bus_cmd_valid <= 1'b0;
            bus_op        <= BUS_OP_RD;
            bus_addr      <= '0;
            bus_wr_data   <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
        end else begin
            bus_cmd_valid <= 1'b0;
            rsp_valid     <= '0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q       <= CMD;
                        ptr_q         <= gnt_idx;
                        idx_q         <= gnt_idx;
                        // Bus fields double as the transaction latch; they hold afterwards.
                        bus_cmd_valid <= 1'b1;
                        bus_op        <= sel_op;
                        bus_addr      <= sel_addr;
                        bus_wr_data   <= sel_wdata;
                    end
                end
                CMD: begin
                    if (bus_op == BUS_OP_WR) begin
                        state_q   <= RSP;
                        rsp_valid <= idx_onehot;
                        rsp_rdata <= '0;
                    end else begin
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    // Slave registers read data, so it is valid in this cycle.
                    state_q   <= RSP;
                    rsp_valid <= idx_onehot;
                    rsp_rdata <= bus_rd_data;
                end
                RSP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Protocol invariants.
    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid));
    a_cmd_single : assert property (@(posedge clk) disable iff (!rst_n)
        bus_cmd_valid |=> !bus_cmd_valid);
    a_ready_idle_only : assert property (@(posedge clk) disable iff (!rst_n)
        (req_ready != '0) |-> (state_q == IDLE));

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: agents drive queued transactions, a reference
// model predicts grants, bus commands and responses, and a monitor compares on the fly.
module tb_reg_bus_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_op;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             bus_cmd_valid;
    logic             bus_op;
    logic [AW-1:0]    bus_addr;
    logic [DW-1:0]    bus_wr_data;
    logic [DW-1:0]    bus_rd_data;

    reg_bus_arbiter #(
        .NUM_REQ (NR),
        .AW      (AW),
        .DW      (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .bus_cmd_valid (bus_cmd_valid),
        .bus_op        (bus_op),
        .bus_addr      (bus_addr),
        .bus_wr_data   (bus_wr_data),
        .bus_rd_data   (bus_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          op;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    typedef struct {
        int          cyc;
        int          idx;
        bit          op;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    txn_t agent_q [NR][$];
    exp_t bus_q[$];
    exp_t rsp_q[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            free_cyc = 0;
    int            last_gnt = NR - 1;
    bit            allow_wd = 1'b0;
    logic [NR-1:0] took     = '0;
    logic [15:0]   slave_mem [16];
    logic [15:0]   model_mem [16];

    // Slave decodes 0x0..0xF except 0x7; anything else reads as zero and ignores writes.
    function automatic bit mapped(logic [15:0] a);
        return (a < 16'd16) && (a != 16'h7);
    endfunction

    function void chk(string name, logic [63:0] got, logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Register slave: read data appears the cycle after the command.
    always @(posedge clk) begin
        if (bus_cmd_valid) begin
            if (bus_op) begin
                if (mapped(bus_addr)) slave_mem[bus_addr[3:0]] <= bus_wr_data;
            end else begin
                bus_rd_data <= mapped(bus_addr) ? slave_mem[bus_addr[3:0]] : 16'h0;
            end
        end
    end

    // Agents: present the head of each queue, retire it once the handshake was seen.
    initial begin
        req_valid = '0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (took[i] && agent_q[i].size() > 0) void'(agent_q[i].pop_front());
                if (agent_q[i].size() > 0) begin
                    req_op[i]              = agent_q[i][0].op;
                    req_addr[i*AW +: AW]   = agent_q[i][0].addr;
                    req_wdata[i*DW +: DW]  = agent_q[i][0].data;
                    req_valid[i]           = !(allow_wd && $urandom_range(7) == 0);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    exp_t          mon_e;
    int            mon_win;
    logic [NR-1:0] mon_gnt;
    logic [NR-1:0] mon_oh;
    logic [15:0]   mon_rd;

    // Monitor + reference model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {req_ready, rsp_valid, bus_cmd_valid, bus_op, bus_addr,
                                  bus_wr_data, rsp_rdata}, 64'h0);
            bus_q.delete();
            rsp_q.delete();
            last_gnt = NR - 1;
            free_cyc = 0;
            took     = '0;
        end else begin
            while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
                mon_e = bus_q.pop_front();
                chk("bus_cmd_missing", 0, 1);
            end
            if (bus_cmd_valid) begin
                if (bus_q.size() == 0) begin
                    chk("bus_cmd_unexpected", 1, 0);
                end else begin
                    mon_e = bus_q.pop_front();
                    chk("bus_cmd_cycle", cyc, mon_e.cyc);
                    chk("bus_op", bus_op, mon_e.op);
                    chk("bus_addr", bus_addr, mon_e.addr);
                    if (mon_e.op) chk("bus_wr_data", bus_wr_data, mon_e.data);
                end
            end

            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                mon_e = rsp_q.pop_front();
                chk("rsp_missing", 0, 1);
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    mon_e = rsp_q.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e.idx] = 1'b1;
                    chk("rsp_cycle", cyc, mon_e.cyc);
                    chk("rsp_valid", rsp_valid, mon_oh);
                    mon_rd = (mon_e.op || !mapped(mon_e.addr)) ? 16'h0
                                                               : model_mem[mon_e.addr[3:0]];
                    chk("rsp_rdata", rsp_rdata, mon_rd);
                    if (mon_e.op && mapped(mon_e.addr)) model_mem[mon_e.addr[3:0]] = mon_e.data;
                end
            end

            // Round robin: first requester after the last winner, only when not busy.
            mon_gnt = '0;
            mon_win = -1;
            if (cyc >= free_cyc) begin
                for (int k = 1; k <= NR; k++) begin
                    if (mon_win < 0 && req_valid[(last_gnt + k) % NR]) mon_win = (last_gnt + k) % NR;
                end
            end
            if (mon_win >= 0) mon_gnt[mon_win] = 1'b1;
            chk("req_ready", req_ready, mon_gnt);
            if (mon_win >= 0) begin
                mon_e.idx  = mon_win;
                mon_e.op   = req_op[mon_win];
                mon_e.addr = req_addr[mon_win*AW +: AW];
                mon_e.data = req_wdata[mon_win*DW +: DW];
                mon_e.cyc  = cyc + 1;
                bus_q.push_back(mon_e);
                mon_e.cyc  = cyc + (mon_e.op ? 2 : 3);
                rsp_q.push_back(mon_e);
                free_cyc   = cyc + (mon_e.op ? 3 : 4);
                last_gnt   = mon_win;
            end
            took = req_valid & req_ready;
        end
    end

    task automatic push(input int a, input bit op, input logic [15:0] addr,
                        input logic [15:0] data);
        txn_t t;
        t.op   = op;
        t.addr = addr;
        t.data = data;
        agent_q[a].push_back(t);
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        bit empty;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            #2;
            empty = (bus_q.size() == 0) && (rsp_q.size() == 0);
            for (int i = 0; i < NR; i++) if (agent_q[i].size() != 0) empty = 1'b0;
            done = empty;
        end
        chk(name, done, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int burst;
        rst_n       = 1'b0;
        bus_rd_data = '0;
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = '0;
            model_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset while the write command is on the bus: it must vanish with no response.
        push(0, 1'b1, 16'h9, 16'h0001);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = bus_cmd_valid;
        end
        chk("abort_cmd_seen", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_bus_cmd_valid", bus_cmd_valid, 0);
        chk("abort_outputs", {req_ready, rsp_valid, bus_op, bus_addr, bus_wr_data, rsp_rdata},
            64'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write then read back on requester 0.
        push(0, 1'b1, 16'h9, 16'h0001);
        push(0, 1'b0, 16'h9, 16'h0000);
        drain("drain_t2");

        // Requester 1 write/read.
        push(1, 1'b1, 16'h5, 16'h1234);
        push(1, 1'b0, 16'h5, 16'h0000);
        drain("drain_t3");

        // All four contend from reset: grant order 0,1,2,3,0.
        pulse_reset();
        push(0, 1'b0, 16'h6, 16'h0);
        push(0, 1'b0, 16'h6, 16'h0);
        push(1, 1'b0, 16'h6, 16'h0);
        push(2, 1'b0, 16'h6, 16'h0);
        push(3, 1'b0, 16'h6, 16'h0);
        drain("drain_t4");

        // Back-to-back writes from a lone requester, then read back.
        push(2, 1'b1, 16'h6, 16'hBEEF);
        push(2, 1'b1, 16'h6, 16'hCAFE);
        push(2, 1'b0, 16'h6, 16'h0);
        drain("drain_t5");

        // Unmapped read; requester 3 arrives while busy.
        push(0, 1'b0, 16'h7, 16'h0);
        repeat (2) @(negedge clk);
        push(3, 1'b1, 16'h3, 16'h55AA);
        push(3, 1'b0, 16'h3, 16'h0);
        drain("drain_t6");

        // Random traffic with withdrawals.
        allow_wd = 1'b1;
        for (int b = 0; b < 12; b++) begin
            burst = $urandom_range(12, 4);
            for (int n = 0; n < burst; n++) begin
                push($urandom_range(NR - 1), 1'($urandom_range(1)),
                     ($urandom_range(9) == 0) ? 16'($urandom) : 16'($urandom_range(15)),
                     16'($urandom));
            end
            repeat ($urandom_range(30)) @(negedge clk);
        end
        drain("drain_random");
        allow_wd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
